pe_array_sequencer: RTL
=======================

Name: pe_array_sequencer

Overview:
- Control FSM that drives the broadcast command bus of the message_passer PE grid. It runs one systolic matrix-multiply pass: clear, load operands, then N multiply steps with A shifted left and B shifted up between them.
- Sits between the host/top-level control and the PE array.
- Owns the array's command, image-select and ack lines; it consumes the AND of all PE ready flags.

Parameters:
- ITER_WIDTH, 4, width of iteration-count input and progress counter.
- TIMEOUT_CYCLES, 256, maximum WAIT cycles before abort (used only with SEQ_TIMEOUT_EN).

Ports:
- CLK  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high; one clock, no other clock domains.
- start  input  1  request a pass; sampled only in IDLE.
- iterations  input  ITER_WIDTH  number of multiply steps N; captured on accepted start.
- ready_all  input  1  AND of every PE ready output.
- ack  output  1  to all PEs; 1 = hold/clear ready, 0 = execute command this cycle.
- command_to_execute  output  3  broadcast PE command (000 mul, 001 shift_up, 011 shift_left, 101 overwrite A/B, 111 reset).
- image_to_shift  output  1  0 = A, 1 = B.
- busy  output  1  high from accepted start until the DONE/abort cycle inclusive.
- done  output  1  one-cycle pulse at successful end of pass.
- iter_count  output  ITER_WIDTH  multiply steps completed in current/last pass.
- error  output  1  one-cycle timeout pulse; constant 0 without SEQ_TIMEOUT_EN.

Behaviour:
- Reset values: ack=1, command_to_execute=3'b111, image_to_shift=0, busy=0, done=0, error=0, iter_count=0, state=IDLE, timeout counter=0. All outputs are registered.
- Reset mid-pass: next cycle is IDLE with reset values. No command is completed.
- Command step, two phases:
  - EXEC: ack=0 for exactly one cycle, with command/image valid.
  - WAIT: ack=1 held until ready_all=1 is sampled, then advance. The next step's EXEC starts the following cycle.
  - Minimum 2 cycles per step. ack is never low for two consecutive cycles, so no PE executes a command twice.
- Command and image hold their values through WAIT. In IDLE/DONE they hold their last value and ack=1.
- Step order for N=iterations:
  1. CLEAR (111).
  2. LOAD (101).
  3. For i=0..N-1: MUL (000). If i<N-1, then SHL (011, image 0) and SHU (001, image 1).
  4. DONE.
- N=0: CLEAR, LOAD, then DONE. iter_count stays 0.
- iter_count: zeroed on accepted start; increments by 1 on each MUL WAIT exit.
- DONE: one cycle with done=1 and busy=1, then IDLE.
- start while busy: ignored. start in the DONE cycle: ignored. start held high in IDLE: a new pass begins each time IDLE is re-entered.
- iterations is sampled only at accepted start; later changes have no effect.
- Latency, N=2 with ready_all=1 throughout: start sampled in IDLE at cycle 0.
  - Cycles 1/2: CLEAR.
  - Cycles 3/4: LOAD.
  - Cycles 5/6: MUL.
  - Cycles 7/8: SHL.
  - Cycles 9/10: SHU.
  - Cycles 11/12: MUL.
  - Cycle 13: done=1.
- ready_all high during EXEC is ignored; only the WAIT-phase sample counts.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - Counter runs in every WAIT cycle and clears on EXEC.
  - If WAIT lasts TIMEOUT_CYCLES cycles without ready_all, the FSM goes to IDLE next cycle: error=1 for one cycle, busy drops, done stays 0, ack=1.
  - iter_count holds its value at abort.
- Undefined: WAIT is unbounded; error tied 0; no counter logic synthesized.

Test Plan:
- Reset, then idle 5 cycles -> ack=1, command 111, busy=0, done=0, iter_count=0 every cycle.
- start with iterations=2, ready_all=1 -> command sequence 111, 101, 000, 011(img0), 001(img1), 000. ack low only at cycles 1,3,5,7,9,11. done at cycle 13. iter_count=2.
- iterations=3, ready_all delayed 4 cycles in each MUL WAIT -> ack held 1 through the delay. Each MUL step takes 5 cycles. Exactly 2 SHL and 2 SHU issued. done once.
- iterations=0 -> only 111 and 101 issued. done at cycle 5. iter_count=0.
- start pulsed again while busy, and reset asserted during the second MUL -> the second start has no effect. After reset, state IDLE, ack=1, busy=0, no done pulse.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready_all held 0 after LOAD EXEC -> error pulses one cycle after 8 WAIT cycles. busy=0, done never asserted. A new start then runs normally.

Source files
------------

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: clear/load/multiply-shift command sequencer for the PE grid; SEQ_TIMEOUT_EN adds a WAIT timeout abort.
module pe_array_sequencer #(
  parameter int ITER_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] iterations,
  input  logic                  ready_all,
  output logic                  ack,
  output logic [2:0]            command_to_execute,
  output logic                  image_to_shift,
  output logic                  busy,
  output logic                  done,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  error
);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, FIN} state_t;
  localparam logic [2:0] CLR = 3'b111, LOAD = 3'b101, MUL = 3'b000, SHL = 3'b011, SHU = 3'b001;
  state_t state_q, state_d;
  logic ack_q, ack_d, img_q, img_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [2:0] cmd_q, cmd_d, nxt_cmd;
  logic [ITER_WIDTH-1:0] iter_q, iter_d, n_q, n_d;
  logic last, tmo_hit;
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  always_ff @(posedge CLK)
    tmo_q <= (reset || state_q != WAIT) ? '0 : tmo_q + 1'b1;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif
  // The current command register doubles as the step identifier.
  assign last    = (cmd_q == LOAD && n_q == '0) || (cmd_q == MUL && iter_q + 1'b1 == n_q);
  assign nxt_cmd = cmd_q == CLR ? LOAD : cmd_q == LOAD ? MUL : cmd_q == MUL ? SHL : cmd_q == SHL ? SHU : MUL;
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b1;
    cmd_d   = cmd_q;
    img_d   = img_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    iter_d  = iter_q;
    n_d     = n_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = EXEC;
        ack_d   = 1'b0;
        cmd_d   = CLR;
        img_d   = 1'b0;
        busy_d  = 1'b1;
        iter_d  = '0;
        n_d     = iterations;
      end
      EXEC: state_d = WAIT;
      WAIT: if (ready_all) begin
        iter_d  = cmd_q == MUL ? iter_q + 1'b1 : iter_q;
        state_d = last ? FIN : EXEC;
        done_d  = last;
        ack_d   = last;
        cmd_d   = last ? cmd_q : nxt_cmd;
        img_d   = last ? img_q : nxt_cmd == SHU;
      end else if (tmo_hit) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b1;
      cmd_q   <= CLR;
      img_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      iter_q  <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      cmd_q   <= cmd_d;
      img_q   <= img_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
      n_q     <= n_d;
    end
  end
  assign ack                = ack_q;
  assign command_to_execute = cmd_q;
  assign image_to_shift     = img_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign iter_count         = iter_q;
  assign error              = err_q;
endmodule
